rst_seq_ctrl: RTL and testbench



---
 rtl/rst_seq_ctrl_if.sv | 29 ++
 rtl/rst_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rst_seq_ctrl_if.sv
// Reset sequencer interface: PLL lock and software request in, reset pair and status out.
interface rst_seq_ctrl_if;
    logic pll_lock;
    logic sw_rst_req;
    logic rst_n_out;
    logic rst;
    logic rst_done;
    logic sw_rst_ack;

    // Environment side: supplies lock and requests, observes the resets.
    modport master (
        output pll_lock,
        output sw_rst_req,
        input  rst_n_out,
        input  rst,
        input  rst_done,
        input  sw_rst_ack
    );

    // Sequencer side.
    modport slave (
        input  pll_lock,
        input  sw_rst_req,
        output rst_n_out,
        output rst,
        output rst_done,
        output sw_rst_ack
    );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: conditions the board reset and PLL lock into a staged reset pair
// (active-low ASIC reset released first, active-high FPGA reset released later) and
// services single-cycle software reset requests with a one-cycle acknowledge.
module rst_seq_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_WAIT   = 16,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned RELEASE_GAP = 4
) (
    input  logic          clk,
    input  logic          arst_n,
    rst_seq_ctrl_if.slave bus
);

    localparam int unsigned MaxLh  = (LOCK_WAIT > HOLD_CYCLES) ? LOCK_WAIT : HOLD_CYCLES;
    localparam int unsigned MaxCnt = (MaxLh > RELEASE_GAP) ? MaxLh : RELEASE_GAP;
    localparam int unsigned CntW   = $clog2(MaxCnt) + 1;
    // The state/output registers act as the last synchroniser stage, so the explicit
    // chains are one flop shorter and the FSM reacts SYNC_STAGES edges after an input.
    localparam int unsigned SyncW  = SYNC_STAGES - 1;

    localparam logic [CntW-1:0] LockLast = CntW'(LOCK_WAIT - 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(RELEASE_GAP - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [2:0] {
        StReset,
        StWaitLock,
        StHold,
        StRelAsic,
        StRun
    } state_e;

    logic [SyncW-1:0] rst_sync_q;
    logic [SyncW-1:0] lock_sync_q;
    logic             arst_s;
    logic             lock_s;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rst_n_out_q, rst_n_out_d;
    logic            rst_q, rst_d;
    logic            rst_done_q, rst_done_d;
    logic            ack_q, ack_d;

    assign arst_s = rst_sync_q[SyncW-1];
    assign lock_s = lock_sync_q[SyncW-1];

    // Synchroniser chains for reset release and PLL lock; both clear asynchronously.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rst_sync_q  <= '0;
            lock_sync_q <= '0;
        end else begin
            rst_sync_q  <= SyncW'({rst_sync_q, 1'b1});
            lock_sync_q <= SyncW'({lock_sync_q, bus.pll_lock});
        end
    end

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;

        unique case (state_q)
            StReset: begin
                if (arst_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end
            end
            StWaitLock: begin
                if (!lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LockLast) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StHold: begin
                if (!lock_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == HoldLast) begin
                    state_d = StRelAsic;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StRelAsic: begin
                if (!lock_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == GapLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StRun: begin
                // Lock loss takes priority over a software request in the same cycle.
                if (!lock_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (bus.sw_rst_req) begin
                    state_d = StHold;
                    cnt_d   = '0;
                    ack_d   = 1'b1;
                end
            end
            default: begin
                state_d = StReset;
                cnt_d   = '0;
            end
        endcase

        // Outputs follow the next state so they change on the transition edge;
        // deriving both from one state keeps rst=0 implying rst_n_out=1.
        rst_n_out_d = (state_d == StRelAsic) || (state_d == StRun);
        rst_d       = (state_d != StRun);
        rst_done_d  = (state_d == StRun);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= StReset;
            cnt_q       <= '0;
            rst_n_out_q <= 1'b0;
            rst_q       <= 1'b1;
            rst_done_q  <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_n_out_q <= rst_n_out_d;
            rst_q       <= rst_d;
            rst_done_q  <= rst_done_d;
            ack_q       <= ack_d;
        end
    end

    assign bus.rst_n_out  = rst_n_out_q;
    assign bus.rst        = rst_q;
    assign bus.rst_done   = rst_done_q;
    assign bus.sw_rst_ack = ack_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with default parameters. Edge numbers in comments
// count rising clk edges after the stimulus change, which is applied 1 ns after an edge.
module tb_rst_seq_ctrl;

    logic clk;
    logic arst_n;
    int   n_vec;
    int   n_err;

    rst_seq_ctrl_if bus ();

    rst_seq_ctrl #(
        .SYNC_STAGES (2),
        .LOCK_WAIT   (16),
        .HOLD_CYCLES (8),
        .RELEASE_GAP (4)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check_all(input string tag, input logic rn, input logic r, input logic done,
                             input logic ack);
        check({tag, ".rst_n_out"}, bus.rst_n_out, rn);
        check({tag, ".rst"}, bus.rst, r);
        check({tag, ".rst_done"}, bus.rst_done, done);
        check({tag, ".sw_rst_ack"}, bus.sw_rst_ack, ack);
    endtask

    // rst_n_out must rise exactly n edges from now and rst must fall 4 edges after that.
    task automatic seq_check(input string tag, input int n);
        ticks(n - 1);
        check_all({tag, ".pre_asic"}, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_all({tag, ".asic_rel"}, 1'b1, 1'b1, 1'b0, 1'b0);
        ticks(3);
        check_all({tag, ".pre_fpga"}, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_all({tag, ".run"}, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    // Released reset must never precede the ASIC release.
    always @(negedge clk) begin
        if (arst_n === 1'b1 && bus.rst === 1'b0) check("order", bus.rst_n_out, 1'b1);
    end

    initial begin
        n_vec          = 0;
        n_err          = 0;
        arst_n         = 1'b1;
        bus.pll_lock   = 1'b1;
        bus.sw_rst_req = 1'b0;

        // Power-on: reset values appear with no clock edge and hold while arst_n is low.
        #1 arst_n = 1'b0;
        #1 check_all("async_por", 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        check_all("por_hold", 1'b0, 1'b1, 1'b0, 1'b0);
        arst_n = 1'b1;
        // WAIT_LOCK at edge 2, ASIC release at 2+24, FPGA release 4 later.
        seq_check("por", 26);

        // Lock glitch in WAIT_LOCK after 10 counted cycles restarts the count.
        arst_n = 1'b0;
        ticks(3);
        arst_n = 1'b1;
        ticks(12);
        bus.pll_lock = 1'b0;
        tick();
        bus.pll_lock = 1'b1;
        // lock_s low at edge 14, good from 15; HOLD at 30, ASIC release at 38.
        seq_check("glitch", 25);

        // Lock loss in RUN: resets reassert on the edge lock_s falls (2 edges later).
        bus.pll_lock = 1'b0;
        tick();
        check_all("lockloss_e1", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check_all("lockloss_e2", 1'b0, 1'b1, 1'b0, 1'b0);
        bus.pll_lock = 1'b1;
        seq_check("relock", 25);

        // Software reset: ack for one cycle, rst_n_out up 8 after ack, rst down 12 after.
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        check_all("sw_ack", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        check_all("sw_ack_end", 1'b0, 1'b1, 1'b0, 1'b0);
        // Request during HOLD is ignored and does not disturb timing.
        tick();
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        check_all("sw_in_hold", 1'b0, 1'b1, 1'b0, 1'b0);
        seq_check("sw_seq", 5);

        // Held request: only the first cycle is accepted.
        bus.sw_rst_req = 1'b1;
        tick();
        check_all("held_ack", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        check("held_no_ack2", bus.sw_rst_ack, 1'b0);
        tick();
        check("held_no_ack3", bus.sw_rst_ack, 1'b0);
        bus.sw_rst_req = 1'b0;
        seq_check("held_seq", 6);

        // Request in the same cycle lock_s falls: lock loss wins, no ack.
        bus.pll_lock = 1'b0;
        tick();
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        check_all("simul", 1'b0, 1'b1, 1'b0, 1'b0);
        bus.pll_lock = 1'b1;
        seq_check("simul_relock", 25);

        // Async reset in REL_ASIC during a software reset, between clock edges.
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        ticks(8);
        check_all("rel_asic", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        #2 arst_n = 1'b0;
        #1 check_all("async_mid", 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5);
        check_all("async_hold", 1'b0, 1'b1, 1'b0, 1'b0);
        arst_n = 1'b1;
        seq_check("restart", 26);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
